// File: rtl/mont_const_gen.sv
// Montgomery constant generator: R mod N and R^2 mod N (R = 2^DATA_LENGTH) by bit-serial modular doubling.
// Define MONT_NPRIME_EN to also produce n' = -N^-1 mod 2^WORD_W; otherwise n_prime reads 0.
module mont_const_gen #(
    parameter int DATA_LENGTH = 1024,
    parameter int WORD_W      = 32,
    parameter int CNT_W       = $clog2(DATA_LENGTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] M_r,
    output logic [DATA_LENGTH-1:0] R_r,
    output logic [DATA_LENGTH-1:0] R_t,
    output logic [WORD_W-1:0]      n_prime,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_R_PH  = 3'd2,
        S_T_PH  = 3'd3,
`ifdef MONT_NPRIME_EN
        S_NP_PH = 3'd4,
`endif
        S_FIN   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [DATA_LENGTH-1:0] r_n;
    logic [DATA_LENGTH-1:0] r_x;
    logic [DATA_LENGTH-1:0] r_rr;
    logic [DATA_LENGTH-1:0] r_rt;
    logic [DATA_LENGTH-1:0] w_x_next;
    logic [DATA_LENGTH:0]   w_dbl;
    logic [CNT_W-1:0]       r_count;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic                   r_bad;
    logic                   w_invalid;
    logic                   w_last;
    logic                   w_ge;

    // x < N keeps 2x < 2N, so one conditional subtract restores the invariant
    assign w_dbl     = {r_x, 1'b0};
    assign w_ge      = (w_dbl >= {1'b0, r_n});
    assign w_x_next  = DATA_LENGTH'(w_ge ? (w_dbl - {1'b0, r_n}) : w_dbl);
    assign w_invalid = (r_n[0] == 1'b0) || (r_n == DATA_LENGTH'(1));
    assign w_last    = (r_count == LAST_CNT);

`ifdef MONT_NPRIME_EN
    localparam int                NP_W    = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [NP_W-1:0]   NP_LAST = NP_W'(WORD_W - 1);

    logic [WORD_W-1:0] r_inv;
    logic [WORD_W-1:0] r_np;
    logic [WORD_W-1:0] w_prod;
    logic [WORD_W-1:0] w_inv_next;
    logic [NP_W-1:0]   r_np_i;
    logic              w_np_last;

    assign w_prod    = r_n[WORD_W-1:0] * r_inv;
    assign w_np_last = (r_np_i == NP_LAST);
    assign n_prime   = r_np;

    // Hensel lifting: adding 2^i flips product bit i because N is odd
    always_comb begin
        w_inv_next = r_inv;
        if (w_prod[r_np_i]) begin
            w_inv_next[r_np_i] = 1'b1;
        end else begin
            w_inv_next[r_np_i] = r_inv[r_np_i];
        end
    end
`else
    assign n_prime = {WORD_W{1'b0}};
`endif

    assign R_r  = r_rr;
    assign R_t  = r_rt;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_CHECK;
                else       w_state_next = S_IDLE;
            end
            S_CHECK: begin
                if (w_invalid) w_state_next = S_FIN;
                else           w_state_next = S_R_PH;
            end
            S_R_PH: begin
                if (w_last) w_state_next = S_T_PH;
                else        w_state_next = S_R_PH;
            end
            S_T_PH: begin
`ifdef MONT_NPRIME_EN
                if (w_last) w_state_next = S_NP_PH;
                else        w_state_next = S_T_PH;
`else
                if (w_last) w_state_next = S_FIN;
                else        w_state_next = S_T_PH;
`endif
            end
`ifdef MONT_NPRIME_EN
            S_NP_PH: begin
                if (w_np_last) w_state_next = S_FIN;
                else           w_state_next = S_NP_PH;
            end
`endif
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath, result and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n     <= {DATA_LENGTH{1'b0}};
            r_x     <= {DATA_LENGTH{1'b0}};
            r_rr    <= {DATA_LENGTH{1'b0}};
            r_rt    <= {DATA_LENGTH{1'b0}};
            r_count <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_bad   <= 1'b0;
`ifdef MONT_NPRIME_EN
            r_inv   <= {WORD_W{1'b0}};
            r_np    <= {WORD_W{1'b0}};
            r_np_i  <= {NP_W{1'b0}};
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n    <= M_r;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_invalid) begin
                        r_bad  <= 1'b1;
                        r_rr   <= {DATA_LENGTH{1'b0}};
                        r_rt   <= {DATA_LENGTH{1'b0}};
                        r_busy <= 1'b0;
`ifdef MONT_NPRIME_EN
                        r_np   <= {WORD_W{1'b0}};
`endif
                    end else begin
                        r_bad   <= 1'b0;
                        r_x     <= DATA_LENGTH'(1);
                        r_count <= {CNT_W{1'b0}};
                    end
                end
                S_R_PH: begin
                    r_x <= w_x_next;
                    if (w_last) begin
                        r_rr    <= w_x_next;
                        r_count <= {CNT_W{1'b0}};
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                S_T_PH: begin
                    r_x <= w_x_next;
                    if (w_last) begin
                        r_rt    <= w_x_next;
                        r_count <= {CNT_W{1'b0}};
`ifdef MONT_NPRIME_EN
                        r_inv   <= WORD_W'(1);
                        r_np_i  <= NP_W'(1);
`else
                        r_busy  <= 1'b0;
`endif
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
`ifdef MONT_NPRIME_EN
                S_NP_PH: begin
                    r_inv <= w_inv_next;
                    if (w_np_last) begin
                        r_np   <= {WORD_W{1'b0}} - w_inv_next;
                        r_busy <= 1'b0;
                    end else begin
                        r_np_i <= r_np_i + NP_W'(1);
                    end
                end
`endif
                S_FIN: begin
                    r_done <= 1'b1;
                    r_err  <= r_bad;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_const_gen.sv
// Self-checking bench for mont_const_gen: vector table, randomized moduli against an arithmetic model, hand corner sequences.
module tb_mont_const_gen;

    localparam int DL8 = 8;
    localparam int DLB = 1024;
`ifdef MONT_NPRIME_EN
    localparam int LAT8 = 2 * DL8 + 2 + 7;
    localparam int LATB = 2 * DLB + 2 + 31;
`else
    localparam int LAT8 = 2 * DL8 + 2;
    localparam int LATB = 2 * DLB + 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_start;
    logic [7:0]       s_m;
    logic [7:0]       s_rr, s_rt, s_np;
    logic             s_busy, s_done, s_err;
    logic             b_start;
    logic [DLB-1:0]   b_m;
    logic [DLB-1:0]   b_rr, b_rt;
    logic [31:0]      b_np;
    logic             b_busy, b_done, b_err;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mont_const_gen #(.DATA_LENGTH(DL8), .WORD_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(s_start), .M_r(s_m),
        .R_r(s_rr), .R_t(s_rt), .n_prime(s_np),
        .busy(s_busy), .done(s_done), .err(s_err)
    );

    mont_const_gen #(.DATA_LENGTH(DLB), .WORD_W(32)) dut_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .M_r(b_m),
        .R_r(b_rr), .R_t(b_rt), .n_prime(b_np),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    typedef struct {
        logic [7:0] m;
        logic [7:0] rr;
        logic [7:0] rt;
        logic       err;
        logic [7:0] np;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [DLB-1:0] act, input logic [DLB-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 2^k mod n, plain integer arithmetic
    function automatic logic [7:0] pow2mod8(input int k, input logic [7:0] n);
        longint r;
        r = (longint'(1) << k) % longint'(n);
        return 8'(r);
    endfunction

    function automatic logic [DLB-1:0] pow2mod_big(input int k, input logic [DLB-1:0] n);
        logic [2*DLB:0] t;
        logic [2*DLB:0] nn;
        t = {(2*DLB+1){1'b0}};
        t[k] = 1'b1;
        nn = {{(DLB+1){1'b0}}, n};
        t = t % nn;
        return t[DLB-1:0];
    endfunction

    // -n^-1 mod 256 by exhaustive search
    function automatic logic [7:0] np_model8(input logic [7:0] n);
        logic [7:0] r;
        r = 8'd0;
`ifdef MONT_NPRIME_EN
        for (int x = 1; x < 256; x += 2) begin
            if (((int'(n) * x) % 256) == 1) r = 8'(256 - x);
        end
`endif
        return r;
    endfunction

    // -n^-1 mod 2^32 by Newton iteration
    function automatic logic [31:0] np_model32(input logic [31:0] n);
        logic [31:0] x;
        x = n;
        for (int i = 0; i < 5; i++) x = x * (32'd2 - n * x);
`ifdef MONT_NPRIME_EN
        return 32'd0 - x;
`else
        return 32'd0;
`endif
    endfunction

    task automatic op8(input logic [7:0] m, output int lat, output int bcnt);
        @(negedge clk);
        s_m = m;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        bcnt = s_busy ? 1 : 0;
        lat = 0;
        while (lat < 200 && !s_done) begin
            @(posedge clk);
            #1;
            lat++;
            if (s_busy) bcnt++;
        end
    endtask

    task automatic opbig(input logic [DLB-1:0] m, output int lat);
        @(negedge clk);
        b_m = m;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        lat = 0;
        while (lat < 3000 && !b_done) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] m, input logic [7:0] rr,
                          input logic [7:0] rt, input logic e, input logic [7:0] np);
        int lat, bc, elat;
        op8(m, lat, bc);
        elat = e ? 2 : LAT8;
        chk({tag, "_latency"}, DLB'(lat), DLB'(elat));
        chk({tag, "_busy_cycles"}, DLB'(bc), DLB'(elat - 1));
        chk({tag, "_R_r"}, DLB'(s_rr), DLB'(rr));
        chk({tag, "_R_t"}, DLB'(s_rt), DLB'(rt));
        chk({tag, "_err"}, DLB'(s_err), DLB'(e));
        chk({tag, "_n_prime"}, DLB'(s_np), DLB'(np));
    endtask

    task automatic checkbig(input string tag, input logic [DLB-1:0] m);
        int lat;
        opbig(m, lat);
        chk({tag, "_latency"}, DLB'(lat), DLB'(LATB));
        chk({tag, "_R_r"}, b_rr, pow2mod_big(DLB, m));
        chk({tag, "_R_t"}, b_rt, pow2mod_big(2 * DLB, m));
        chk({tag, "_err"}, DLB'(b_err), DLB'(0));
        chk({tag, "_n_prime"}, DLB'(b_np), DLB'(np_model32(m[31:0])));
    endtask

    initial begin
        logic [7:0]     m8;
        logic [7:0]     exp_np;
        logic [DLB-1:0] mb;
        int             lat, bc, k, dn;

        tbl[0]  = '{m: 8'd13,  rr: 8'd9, rt: 8'd3, err: 1'b0, np: 8'd59};
        tbl[1]  = '{m: 8'd255, rr: 8'd1, rt: 8'd1, err: 1'b0, np: 8'd1};
        tbl[2]  = '{m: 8'd13,  rr: 8'd9, rt: 8'd3, err: 1'b0, np: 8'd59};
        tbl[3]  = '{m: 8'd4,   rr: 8'd0, rt: 8'd0, err: 1'b1, np: 8'd0};
        tbl[4]  = '{m: 8'd1,   rr: 8'd0, rt: 8'd0, err: 1'b1, np: 8'd0};
        tbl[5]  = '{m: 8'd13,  rr: 8'd9, rt: 8'd3, err: 1'b0, np: 8'd59};
        tbl[6]  = '{m: 8'd0,   rr: 8'd0, rt: 8'd0, err: 1'b1, np: 8'd0};
        tbl[7]  = '{m: 8'd3,   rr: 8'd1, rt: 8'd1, err: 1'b0, np: 8'd85};
        tbl[8]  = '{m: 8'd5,   rr: 8'd1, rt: 8'd1, err: 1'b0, np: 8'd51};
        tbl[9]  = '{m: 8'd253, rr: 8'd3, rt: 8'd9, err: 1'b0, np: 8'd171};
        tbl[10] = '{m: 8'd254, rr: 8'd0, rt: 8'd0, err: 1'b1, np: 8'd0};
        tbl[11] = '{m: 8'd7,   rr: 8'd4, rt: 8'd2, err: 1'b0, np: 8'd73};

        rst_n = 1'b0;
        s_start = 1'b0;
        s_m = 8'd0;
        b_start = 1'b0;
        b_m = {DLB{1'b0}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_R_r", DLB'(s_rr), DLB'(0));
        chk("rst_R_t", DLB'(s_rt), DLB'(0));
        chk("rst_n_prime", DLB'(s_np), DLB'(0));
        chk("rst_busy", DLB'(s_busy), DLB'(0));
        chk("rst_done", DLB'(s_done), DLB'(0));
        chk("rst_err", DLB'(s_err), DLB'(0));
        chk("rst_big_R_t", b_rt, DLB'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Table entries run back to back: each start is sampled right after the previous done
        for (int i = 0; i < 12; i++) begin
            exp_np = tbl[i].np;
`ifndef MONT_NPRIME_EN
            exp_np = 8'd0;
`endif
            check8($sformatf("tbl%0d", i), tbl[i].m, tbl[i].rr, tbl[i].rt, tbl[i].err, exp_np);
        end

        for (int i = 0; i < 16; i++) begin
            m8 = 8'(2 * $urandom_range(1, 127) + 1);
            check8($sformatf("rnd%0d_m%0d", i, m8), m8, pow2mod8(DL8, m8), pow2mod8(2 * DL8, m8),
                   1'b0, np_model8(m8));
        end

        // Start/modulus changes while busy are ignored; R_t keeps its old value until T_PH ends
        op8(8'd255, lat, bc);
        chk("hold_pre_R_t", DLB'(s_rt), DLB'(1));
        @(negedge clk);
        s_m = 8'd13;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                s_start = 1'b1;
                s_m = 8'd255;
            end
            if (i == 8) s_start = 1'b0;
        end
        chk("mid_R_r", DLB'(s_rr), DLB'(9));
        chk("mid_R_t_held", DLB'(s_rt), DLB'(1));
        k = 0;
        while (s_busy && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("busy_fall", DLB'(k), DLB'(LAT8 - 1 - 9));
        s_start = 1'b1;
        s_m = 8'd255;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        chk("ign_done", DLB'(s_done), DLB'(1));
        chk("ign_R_r", DLB'(s_rr), DLB'(9));
        chk("ign_R_t", DLB'(s_rt), DLB'(3));
        @(posedge clk);
        #1;
        chk("done_one_cycle", DLB'(s_done), DLB'(0));
        chk("fin_start_ignored", DLB'(s_busy), DLB'(0));

        // Reset in the middle of an operation discards it
        @(negedge clk);
        s_m = 8'd13;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_busy", DLB'(s_busy), DLB'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mrst_R_r", DLB'(s_rr), DLB'(0));
        chk("mrst_R_t", DLB'(s_rt), DLB'(0));
        chk("mrst_busy", DLB'(s_busy), DLB'(0));
        chk("mrst_done", DLB'(s_done), DLB'(0));
        chk("mrst_n_prime", DLB'(s_np), DLB'(0));
        dn = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (s_done || s_busy) dn++;
        end
        chk("mrst_no_activity", DLB'(dn), DLB'(0));
        check8("post_rst", 8'd13, 8'd9, 8'd3, 1'b0, np_model8(8'd13));

        // Full-width moduli
        mb = {DLB{1'b1}};
        checkbig("big_all_ones", mb);
        chk("big_all_ones_R_r_const", b_rr, DLB'(1));
        chk("big_all_ones_R_t_const", b_rt, DLB'(1));
        mb = {DLB{1'b0}};
        mb[DLB-1] = 1'b1;
        mb[0] = 1'b1;
        checkbig("big_2p1023p1", mb);
        mb = {DLB{1'b1}};
        mb[DLB-1] = 1'b0;
        chk("big_2p1023p1_R_r_const", b_rr, mb);
        chk("big_2p1023p1_R_t_const", b_rt, DLB'(4));
        for (int w = 0; w < DLB / 32; w++) mb[w*32 +: 32] = $urandom;
        mb[DLB-1] = 1'b1;
        mb[0] = 1'b1;
        checkbig("big_rnd", mb);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mont_const_gen.md
Name: mont_const_gen

Overview:
Parametrised successor to the fixed 1024-bit R/T constant block. Given an odd modulus N, it computes the Montgomery constants R mod N and R^2 mod N, where R = 2^DATA_LENGTH, using bit-serial modular doubling (one doubling per cycle).
Sits ahead of the Montgomery multiplier in the RSA decryption datapath. It adds synchronous reset, busy/error reporting, input latching and start-while-busy rules.

Parameters:
DATA_LENGTH, 1024, modulus/result width in bits (>= 4).
WORD_W, 32, multiplier word width, used only by the optional n' output.
CNT_W, $clog2(DATA_LENGTH)+1, iteration counter width (derived; do not override).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
start  in  1  request; sampled only in IDLE.
M_r  in  DATA_LENGTH  modulus N; latched on the accepted start.
R_r  out  DATA_LENGTH  R mod N.
R_t  out  DATA_LENGTH  R^2 mod N.
n_prime  out  WORD_W  -N^-1 mod 2^WORD_W; reads 0 when MONT_NPRIME_EN is undefined.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle completion pulse.
err  out  1  high with done when N is invalid; held until the next accepted start.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; R_r, R_t, n_prime, x, count = 0; busy, done, err = 0. Reset wins over every other event, including mid-operation; the partial result is discarded.
- IDLE:
  - start=1 latches N<=M_r, clears err, sets busy.
  - Next state is CHECK.
  - start while busy is ignored, not queued.
- CHECK (1 cycle):
  - N[0]=0 or N<=1: go to FIN with err=1, R_r=R_t=n_prime=0.
  - Otherwise x<=1, count<=0, go to R_PH.
- R_PH (DATA_LENGTH cycles):
  - Each cycle: d = {x,1'b0} (DATA_LENGTH+1 bits); x <= (d >= N) ? d-N : d. Invariant x < N holds always.
  - count increments each cycle.
  - On the last cycle (count == DATA_LENGTH-1) R_r <= next x; go to T_PH, count<=0.
- T_PH (DATA_LENGTH cycles): same doubling, continuing from x = R mod N. Final x = 2^(2*DATA_LENGTH) mod N, written to R_t.
  - Next state is NP_PH if MONT_NPRIME_EN, else FIN.
- FIN (1 cycle): done=1, busy=0; next state IDLE.
  - R_r, R_t, n_prime and err hold until the next accepted start.
  - R_r updates at the end of R_PH; R_t updates only at the end of T_PH.
- Latency: done is asserted 2*DATA_LENGTH+2 cycles after the start-sampling edge, or +(WORD_W-1) with MONT_NPRIME_EN. The error path asserts done 2 cycles after the start-sampling edge.
- start asserted in the FIN cycle is ignored. start sampled on the cycle after done (back in IDLE) is accepted.
- Arithmetic is unsigned only; no multiplier in the R/T path.

Optional Feature:
MONT_NPRIME_EN. Defined:
- Adds state NP_PH, WORD_W-1 cycles, after T_PH.
- inv starts at 1. For i = 1..WORD_W-1: if bit i of (N[WORD_W-1:0]*inv mod 2^WORD_W) is 1, set inv[i]<=1.
- At the end, n_prime <= (2^WORD_W - inv) mod 2^WORD_W.
- The error path leaves n_prime = 0.
Undefined: no NP_PH state and no multiplier; n_prime is tied to 0; latency excludes the NP term.

Test Plan:
- DATA_LENGTH=8, M_r=13, start pulse -> done after 18 cycles, R_r=9, R_t=3, err=0, busy high for exactly 17 cycles.
- DATA_LENGTH=8, M_r=255 -> R_r=1, R_t=1. Then back-to-back: start on the cycle after done with M_r=13 -> R_r=9, R_t=3.
- DATA_LENGTH=8, M_r=4 -> done 2 cycles after start, err=1, R_r=R_t=0. Then M_r=1 -> err=1. Then M_r=13 -> err cleared, valid results.
- Start with M_r=13; toggle start and change M_r to 255 during busy -> ignored, R_r=9, R_t=3. rst_n=0 at cycle 6 -> next cycle all outputs 0, state IDLE, no done pulse.
- MONT_NPRIME_EN, DATA_LENGTH=8, WORD_W=8: M_r=13 -> n_prime=59, done after 25 cycles. M_r=255 -> n_prime=1.
- DATA_LENGTH=1024, N = 2^1024-1 -> R_r=1, R_t=1. N = 2^1023+1 -> R_r = 2^1023-1 and R_t = 4, both checked against a bignum model.
